// File: rtl/hood_mode_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hood_mode_ctrl_if
// Description : Button/tick inputs and wind-mode outputs of the hood mode
//               controller, bundled for the controller and its driver.
// Revision    : 1.0 - initial release
// ============================================================================
interface hood_mode_ctrl_if;
    logic       tick_1hz;
    logic       menu_btn;
    logic       mode1_btn;
    logic       mode2_btn;
    logic       mode3_btn;
    logic [2:0] mode_state;
    logic       power_on;
    logic       hurricane_used;
    logic [6:0] countdown_sec;

    modport master (
        output tick_1hz, menu_btn, mode1_btn, mode2_btn, mode3_btn,
        input  mode_state, power_on, hurricane_used, countdown_sec
    );

    modport slave (
        input  tick_1hz, menu_btn, mode1_btn, mode2_btn, mode3_btn,
        output mode_state, power_on, hurricane_used, countdown_sec
    );
endinterface
`default_nettype wire

// File: rtl/hood_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hood_mode_ctrl
// Description : Range-hood wind mode FSM with one-shot hurricane boost and
//               timed forced-exhaust cooldown after a hurricane abort.
// Revision    : 1.0 - initial release
// ============================================================================
module hood_mode_ctrl #(
    parameter int HURRICANE_SEC = 60,
    parameter int COOLDOWN_SEC  = 60
) (
    input  wire logic       clk,
    input  wire logic       rst,
    hood_mode_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_STANDBY  = 3'd1,
        S_MODE1    = 3'd2,
        S_MODE2    = 3'd3,
        S_HURR     = 3'd4,
        S_COOLDOWN = 3'd5
    } state_t;

    localparam logic [6:0] C_HURR_LOAD = 7'(HURRICANE_SEC);
    localparam logic [6:0] C_COOL_LOAD = 7'(COOLDOWN_SEC);

    state_t     state_q, state_d;
    logic [3:0] btn_prev_q, btn_prev_d;
    logic [6:0] countdown_q, countdown_d;
    logic       used_q, used_d;
    logic [2:0] mode_state_q, mode_state_d;
    logic       power_on_q, power_on_d;

    logic [3:0] btn_now;
    logic [3:0] rise;
    logic       press_menu, press_m3, press_m2, press_m1;
    logic       can_hurr;

    always_comb begin
        // Bit order {mode3, mode2, mode1, menu}
        btn_now    = {bus.mode3_btn, bus.mode2_btn, bus.mode1_btn, bus.menu_btn};
        btn_prev_d = btn_now;
        rise       = btn_now & ~btn_prev_q;

        press_menu = rise[0];
        press_m3   = rise[3] & ~rise[0];
        press_m2   = rise[2] & ~rise[3] & ~rise[0];
        press_m1   = rise[1] & ~rise[2] & ~rise[3] & ~rise[0];
        can_hurr   = press_m3 & ~used_q;

        state_d     = state_q;
        countdown_d = countdown_q;
        used_d      = used_q;

        case (state_q)
            S_OFF: begin
                if (press_menu) begin
                    state_d     = S_STANDBY;
                    countdown_d = 7'd0;
                end
            end
            S_STANDBY, S_MODE1, S_MODE2: begin
                if (press_menu) begin
                    state_d     = (state_q == S_STANDBY) ? S_OFF : S_STANDBY;
                    countdown_d = 7'd0;
                    if (state_q == S_STANDBY) begin
                        used_d = 1'b0;
                    end
                end else if (can_hurr) begin
                    state_d     = S_HURR;
                    countdown_d = C_HURR_LOAD;
                    used_d      = 1'b1;
                end else if (press_m2) begin
                    state_d     = S_MODE2;
                    countdown_d = 7'd0;
                end else if (press_m1) begin
                    state_d     = S_MODE1;
                    countdown_d = 7'd0;
                end
            end
            S_HURR: begin
                // An accepted menu press swallows a coincident tick
                if (press_menu) begin
                    state_d     = S_COOLDOWN;
                    countdown_d = C_COOL_LOAD;
                end else if (bus.tick_1hz) begin
                    if (countdown_q <= 7'd1) begin
                        state_d     = S_MODE2;
                        countdown_d = 7'd0;
                    end else begin
                        countdown_d = countdown_q - 7'd1;
                    end
                end
            end
            S_COOLDOWN: begin
                if (bus.tick_1hz) begin
                    if (countdown_q <= 7'd1) begin
                        state_d     = S_STANDBY;
                        countdown_d = 7'd0;
                    end else begin
                        countdown_d = countdown_q - 7'd1;
                    end
                end
            end
            default: begin
                state_d     = S_OFF;
                countdown_d = 7'd0;
                used_d      = 1'b0;
            end
        endcase

        case (state_d)
            S_MODE1:    mode_state_d = 3'b001;
            S_MODE2:    mode_state_d = 3'b010;
            S_HURR:     mode_state_d = 3'b011;
            S_COOLDOWN: mode_state_d = 3'b100;
            default:    mode_state_d = 3'b000;
        endcase
        power_on_d = (state_d != S_OFF);
    end

    // Previous-value flops reset high so a button held through reset is not a press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_OFF;
            btn_prev_q   <= 4'b1111;
            countdown_q  <= 7'd0;
            used_q       <= 1'b0;
            mode_state_q <= 3'b000;
            power_on_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            btn_prev_q   <= btn_prev_d;
            countdown_q  <= countdown_d;
            used_q       <= used_d;
            mode_state_q <= mode_state_d;
            power_on_q   <= power_on_d;
        end
    end

    assign bus.mode_state     = mode_state_q;
    assign bus.power_on       = power_on_q;
    assign bus.hurricane_used = used_q;
    assign bus.countdown_sec  = countdown_q;

endmodule
`default_nettype wire

// File: tb/tb_hood_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hood_mode_ctrl
// Description : Scoreboard bench driving two hood_mode_ctrl instances with
//               different timer lengths from one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hood_mode_ctrl;

    typedef struct {
        logic [2:0] ms;
        logic       on;
        logic       used;
        logic [6:0] cd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mn = 1'b0, b1 = 1'b0, b2 = 1'b0, b3 = 1'b0, tk = 1'b0;

    hood_mode_ctrl_if bus_a ();
    hood_mode_ctrl_if bus_b ();

    assign bus_a.menu_btn  = mn;
    assign bus_a.mode1_btn = b1;
    assign bus_a.mode2_btn = b2;
    assign bus_a.mode3_btn = b3;
    assign bus_a.tick_1hz  = tk;
    assign bus_b.menu_btn  = mn;
    assign bus_b.mode1_btn = b1;
    assign bus_b.mode2_btn = b2;
    assign bus_b.mode3_btn = b3;
    assign bus_b.tick_1hz  = tk;

    hood_mode_ctrl #(.HURRICANE_SEC(3), .COOLDOWN_SEC(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    hood_mode_ctrl #(.HURRICANE_SEC(5), .COOLDOWN_SEC(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    // Reference model: powered flag, wind level as the output code, seconds left
    bit m_pow[2];
    int m_wind[2];
    int m_cnt[2];
    bit m_used[2];
    int hurr_len[2] = '{3, 5};
    int cool_len[2] = '{2, 2};
    bit pv[4];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pow[k]  = 1'b0;
            m_wind[k] = 0;
            m_cnt[k]  = 0;
            m_used[k] = 1'b0;
        end
        for (int j = 0; j < 4; j++) pv[j] = 1'b1;
    endfunction

    function automatic void model_step(bit i_mn, bit i_b1, bit i_b2, bit i_b3, bit i_tk);
        int p;
        bit r_mn, r_b1, r_b2, r_b3;
        r_mn = i_mn & !pv[0];
        r_b1 = i_b1 & !pv[1];
        r_b2 = i_b2 & !pv[2];
        r_b3 = i_b3 & !pv[3];
        // 4 = menu; otherwise the highest-priority mode number pressed
        p = r_mn ? 4 : r_b3 ? 3 : r_b2 ? 2 : r_b1 ? 1 : 0;
        for (int k = 0; k < 2; k++) begin
            if (!m_pow[k]) begin
                if (p == 4) begin
                    m_pow[k]  = 1'b1;
                    m_wind[k] = 0;
                end
            end else if (m_wind[k] == 3) begin
                if (p == 4) begin
                    m_wind[k] = 4;
                    m_cnt[k]  = cool_len[k];
                end else if (i_tk) begin
                    m_cnt[k] = m_cnt[k] - 1;
                    if (m_cnt[k] == 0) m_wind[k] = 2;
                end
            end else if (m_wind[k] == 4) begin
                if (i_tk) begin
                    m_cnt[k] = m_cnt[k] - 1;
                    if (m_cnt[k] == 0) m_wind[k] = 0;
                end
            end else begin
                if (p == 4) begin
                    if (m_wind[k] == 0) begin
                        m_pow[k]  = 1'b0;
                        m_used[k] = 1'b0;
                    end else begin
                        m_wind[k] = 0;
                    end
                end else if (p == 3) begin
                    if (!m_used[k]) begin
                        m_wind[k] = 3;
                        m_cnt[k]  = hurr_len[k];
                        m_used[k] = 1'b1;
                    end
                end else if (p == 2) begin
                    m_wind[k] = 2;
                end else if (p == 1) begin
                    m_wind[k] = 1;
                end
            end
        end
        pv[0] = i_mn;
        pv[1] = i_b1;
        pv[2] = i_b2;
        pv[3] = i_b3;
    endfunction

    function automatic exp_t model_out(int k);
        exp_t e;
        e.ms   = m_pow[k] ? 3'(m_wind[k]) : 3'd0;
        e.on   = m_pow[k];
        e.used = m_used[k];
        e.cd   = 7'(m_cnt[k]);
        return e;
    endfunction

    // Called at a falling edge; returns at the next falling edge
    task automatic cycle(input bit i_mn, input bit i_b1, input bit i_b2, input bit i_b3, input bit i_tk);
        mn = i_mn; b1 = i_b1; b2 = i_b2; b3 = i_b3; tk = i_tk;
        model_step(i_mn, i_b1, i_b2, i_b3, i_tk);
        qa.push_back(model_out(0));
        qb.push_back(model_out(1));
        @(negedge clk);
    endtask

    task automatic press(input bit i_mn, input bit i_b1, input bit i_b2, input bit i_b3, input bit i_tk);
        cycle(i_mn, i_b1, i_b2, i_b3, i_tk);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Reset asserted between edges must clear outputs without a clock
    task automatic mid_cycle_reset();
        tk = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst.a.mode_state", bus_a.mode_state, 0);
        chk("async_rst.a.power_on", bus_a.power_on, 0);
        chk("async_rst.a.used", bus_a.hurricane_used, 0);
        chk("async_rst.a.countdown", bus_a.countdown_sec, 0);
        chk("async_rst.b.mode_state", bus_b.mode_state, 0);
        chk("async_rst.b.countdown", bus_b.countdown_sec, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    always @(posedge clk) begin
        #1;
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            eb = qb.pop_front();
            chk("a.mode_state", bus_a.mode_state, ea.ms);
            chk("a.power_on", bus_a.power_on, ea.on);
            chk("a.hurricane_used", bus_a.hurricane_used, ea.used);
            chk("a.countdown_sec", bus_a.countdown_sec, ea.cd);
            chk("b.mode_state", bus_b.mode_state, eb.ms);
            chk("b.power_on", bus_b.power_on, eb.on);
            chk("b.hurricane_used", bus_b.hurricane_used, eb.used);
            chk("b.countdown_sec", bus_b.countdown_sec, eb.cd);
        end
    end

    initial begin
        model_reset();
        #1;
        chk("reset.mode_state", bus_a.mode_state, 0);
        chk("reset.power_on", bus_a.power_on, 0);
        chk("reset.countdown", bus_b.countdown_sec, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Power-up walk: STANDBY, MODE1, MODE2
        press(1, 0, 0, 0, 0);
        press(0, 1, 0, 0, 0);
        press(0, 0, 1, 0, 0);
        // Hurricane from MODE1, expiry, then refused second hurricane
        press(0, 1, 0, 0, 0);
        press(0, 0, 0, 1, 0);
        tick(); tick(); tick();
        press(0, 0, 0, 1, 0);
        // Session reset: OFF and back clears the one-shot
        press(1, 0, 0, 0, 0);
        press(1, 0, 0, 0, 0);
        press(1, 0, 0, 0, 0);
        press(0, 0, 0, 1, 0);
        // Abort with coincident tick, menu ignored in cooldown, expiry to STANDBY
        tick();
        press(1, 0, 0, 0, 1);
        press(1, 0, 0, 0, 0);
        tick(); tick();
        // Priority: menu beats mode1, mode3 beats mode1
        press(0, 0, 1, 0, 0);
        press(1, 1, 0, 0, 0);
        press(1, 0, 0, 0, 0);
        press(1, 0, 0, 0, 0);
        press(0, 1, 0, 1, 0);
        tick();
        mid_cycle_reset();
        // Menu held across reset release is not a press
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        mid_cycle_reset();
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        press(1, 0, 0, 0, 0);

        for (int i = 0; i < 800; i++) begin
            if (i % 250 == 249) begin
                mid_cycle_reset();
            end
            cycle(($urandom_range(0, 9) == 0) ? !mn : mn,
                  ($urandom_range(0, 5) == 0) ? !b1 : b1,
                  ($urandom_range(0, 5) == 0) ? !b2 : b2,
                  ($urandom_range(0, 4) == 0) ? !b3 : b3,
                  $urandom_range(0, 2) == 0);
        end

        @(negedge clk);
        chk("scoreboard_drained", qa.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
